// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder_nm registered one-hot decoder.
//   mode_e  : command mode carried on the mode input
//   state_e : control FSM states
//   clog2   : ceiling log2 for parameter-derived widths
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_PULSE,
    ST_SCAN
  } state_e;

  // Returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational index-to-one-hot decoder.
//   idx      : input index, SEL_W bits
//   onehot   : N_OUT-bit one-hot of idx; all-zero when idx >= N_OUT
//   in_range : high when idx < N_OUT
module decoder_onehot #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned N_OUT = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  output logic [N_OUT-1:0] onehot,
  output logic             in_range
);

  // One extra bit so N_OUT = 2^SEL_W is representable.
  assign in_range = ({1'b0, idx} < (SEL_W + 1)'(N_OUT));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      onehot[i] = (idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/decoder_nm.sv
// Registered binary-to-one-hot decoder with HOLD / PULSE / SCAN output modes.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : block enable; low clears outputs and aborts any operation
//   in_valid   : command valid; in_ready accepts it (IDLE or HOLD only)
//   sel, mode  : output index and mode (00 HOLD, 01 PULSE, 10 SCAN, 11 clear)
//   y          : registered one-hot (or all-zero) output bus
//   busy       : high while a PULSE or SCAN is in progress
//   err        : sticky out-of-range flag, present only when DECN_RANGE_CHECK_EN is defined
module decoder_nm
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned N_OUT      = 1 << SEL_W,
  parameter int unsigned SCAN_DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  output logic [N_OUT-1:0] y,
  output logic             busy
`ifdef DECN_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned DW = (clog2(SCAN_DWELL) < 1) ? 1 : clog2(SCAN_DWELL);
  localparam logic [DW-1:0]    DwellLast = DW'(SCAN_DWELL - 1);
  localparam logic [SEL_W-1:0] PosLast   = SEL_W'(N_OUT - 1);

  state_e           state_q, state_d;
  logic [N_OUT-1:0] y_q, y_d;
  logic [SEL_W-1:0] pos_q, pos_d;
  logic [SEL_W-1:0] step_q, step_d;   // positions already completed in this scan
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             err_q, err_d;

  logic [SEL_W-1:0] pos_next;
  logic [N_OUT-1:0] sel_oh, pos_oh;
  logic             sel_ok, pos_ok;
  logic             accept;

  // Wrap at N_OUT rather than 2^SEL_W.
  assign pos_next = (pos_q == PosLast) ? '0 : pos_q + 1'b1;

  decoder_onehot #(
    .SEL_W(SEL_W),
    .N_OUT(N_OUT)
  ) u_sel_dec (
    .idx     (sel),
    .onehot  (sel_oh),
    .in_range(sel_ok)
  );

  decoder_onehot #(
    .SEL_W(SEL_W),
    .N_OUT(N_OUT)
  ) u_pos_dec (
    .idx     (pos_next),
    .onehot  (pos_oh),
    .in_range(pos_ok)
  );

  assign in_ready = en & rst_n & ((state_q == ST_IDLE) | (state_q == ST_HOLD));
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q == ST_PULSE) | (state_q == ST_SCAN);
  assign y        = y_q;
`ifdef DECN_RANGE_CHECK_EN
  assign err      = err_q;
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    pos_d   = pos_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    err_d   = err_q;
    if (!en) begin
      state_d = ST_IDLE;
      y_d     = '0;
      pos_d   = '0;
      step_d  = '0;
      dwell_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      // Out-of-range and reserved commands both land in IDLE with y cleared.
      state_d = ST_IDLE;
      y_d     = '0;
      pos_d   = sel;
      step_d  = '0;
      dwell_d = '0;
      if (!sel_ok) begin
`ifdef DECN_RANGE_CHECK_EN
        err_d = 1'b1;
`endif
      end else begin
        unique case (mode_e'(mode))
          MODE_HOLD: begin
            y_d     = sel_oh;
            state_d = ST_HOLD;
          end
          MODE_PULSE: begin
            y_d     = sel_oh;
            state_d = ST_PULSE;
          end
          MODE_SCAN: begin
            y_d     = sel_oh;
            state_d = ST_SCAN;
          end
          default: ;
        endcase
      end
    end else begin
      unique case (state_q)
        ST_PULSE: begin
          y_d     = '0;
          state_d = ST_IDLE;
        end
        ST_SCAN: begin
          if (dwell_q == DwellLast) begin
            dwell_d = '0;
            if (step_q == PosLast) begin
              y_d     = '0;
              state_d = ST_IDLE;
            end else begin
              pos_d  = pos_next;
              step_d = step_q + 1'b1;
              y_d    = pos_oh & {N_OUT{pos_ok}};
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      pos_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
    end
  end

`ifndef DECN_RANGE_CHECK_EN
  logic unused_err;
  assign unused_err = err_q ^ err_d;
`endif

endmodule

// File: tb/tb_decoder_nm.sv
// Self-checking bench for decoder_nm (SEL_W=3, N_OUT=5, SCAN_DWELL=2).
// A queue-based model predicts y/busy/in_ready/err every cycle; directed
// literal checks pin HOLD, PULSE, SCAN walk, abort, range and async reset.
module tb_decoder_nm;

  localparam int SW = 3;
  localparam int N  = 5;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sel;
  logic [1:0]    mode;
  logic [N-1:0]  y;
  logic          busy;
  logic          err_w;

  int checks   = 0;
  int failures = 0;

  // Model state: current y, queue of future y values, sticky err.
  logic [N-1:0] m_y;
  logic [N-1:0] pend[$];
  logic         m_err;

  logic [N-1:0] scan_exp [10];

  always #5 clk = ~clk;

  decoder_nm #(
    .SEL_W     (SW),
    .N_OUT     (N),
    .SCAN_DWELL(D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel     (sel),
    .mode    (mode),
    .y       (y),
    .busy    (busy)
`ifdef DECN_RANGE_CHECK_EN
    ,
    .err     (err_w)
`endif
  );

`ifndef DECN_RANGE_CHECK_EN
  assign err_w = 1'b0;
`endif

  function automatic logic [N-1:0] oh(input int p);
    logic [N-1:0] v;
    v = '0;
    if (p >= 0 && p < N) v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic model_ready();
    return rst_n && en && (pend.size() == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model.
  initial begin
    m_y   = '0;
    m_err = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || !en) begin
        m_y = '0;
        pend.delete();
        m_err = 1'b0;
      end else if (in_valid && model_ready()) begin
        pend.delete();
        if (int'(sel) >= N) begin
          m_y = '0;
`ifdef DECN_RANGE_CHECK_EN
          m_err = 1'b1;
`endif
        end else begin
          case (mode)
            2'b00: m_y = oh(int'(sel));
            2'b01: begin
              m_y = oh(int'(sel));
              pend.push_back('0);
            end
            2'b10: begin
              m_y = oh(int'(sel));
              for (int t = 1; t < N * D; t++) pend.push_back(oh((int'(sel) + t / D) % N));
              pend.push_back('0);
            end
            default: m_y = '0;
          endcase
        end
      end else if (pend.size() > 0) begin
        m_y = pend.pop_front();
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_y", 32'(y), 32'(m_y));
      chk("cmp_busy", 32'(busy), 32'(pend.size() > 0));
      chk("cmp_in_ready", 32'(in_ready), 32'(model_ready()));
`ifdef DECN_RANGE_CHECK_EN
      chk("cmp_err", 32'(err_w), 32'(m_err));
`endif
    end
  end

  task automatic issue(input logic [SW-1:0] s, input logic [1:0] m);
    in_valid = 1'b1;
    sel      = s;
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    scan_exp = '{5'b01000, 5'b01000, 5'b10000, 5'b10000, 5'b00001,
                 5'b00001, 5'b00010, 5'b00010, 5'b00100, 5'b00100};
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    sel      = '0;
    mode     = '0;
    #3;
    chk("reset_y", 32'(y), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'h1);

    // HOLD, then replace the HOLD.
    issue(3'd2, 2'b00);
    chk("hold_y_sel2", 32'(y), 32'h04);
    chk("hold_in_ready", 32'(in_ready), 32'h1);
    issue(3'd1, 2'b00);
    chk("hold_y_sel1", 32'(y), 32'h02);
    chk("hold_in_ready2", 32'(in_ready), 32'h1);

    // PULSE.
    issue(3'd3, 2'b01);
    chk("pulse_y", 32'(y), 32'h08);
    chk("pulse_in_ready", 32'(in_ready), 32'h0);
    chk("pulse_busy", 32'(busy), 32'h1);
    tick();
    chk("pulse_y_after", 32'(y), 32'h0);
    chk("pulse_busy_after", 32'(busy), 32'h0);

    // SCAN walk with wrap 4 -> 0.
    issue(3'd3, 2'b10);
    for (int t = 0; t < 10; t++) begin
      chk("scan_y", 32'(y), 32'(scan_exp[t]));
      chk("scan_busy", 32'(busy), 32'h1);
      tick();
    end
    chk("scan_end_y", 32'(y), 32'h0);
    chk("scan_end_busy", 32'(busy), 32'h0);

    // Abort on cycle 3 with in_valid held high.
    issue(3'd0, 2'b10);
    tick();
    en       = 1'b0;
    in_valid = 1'b1;
    sel      = 3'd1;
    mode     = 2'b00;
    tick();
    chk("abort_y", 32'(y), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("abort_y_held", 32'(y), 32'h0);
    in_valid = 1'b0;
    en       = 1'b1;
    tick();
    chk("abort_resume_ready", 32'(in_ready), 32'h1);

    // Out-of-range select.
    issue(3'd6, 2'b10);
    chk("range_y", 32'(y), 32'h0);
    chk("range_busy", 32'(busy), 32'h0);
`ifdef DECN_RANGE_CHECK_EN
    chk("range_err", 32'(err_w), 32'h1);
`endif
    issue(3'd2, 2'b00);
    chk("range_hold_y", 32'(y), 32'h04);
`ifdef DECN_RANGE_CHECK_EN
    chk("range_err_sticky", 32'(err_w), 32'h1);
`endif
    en = 1'b0;
    tick();
    en = 1'b1;
`ifdef DECN_RANGE_CHECK_EN
    chk("range_err_clear", 32'(err_w), 32'h0);
`endif

    // Asynchronous reset mid-SCAN.
    tick();
    issue(3'd1, 2'b10);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_y", 32'(y), 32'h0);
    chk("areset_busy", 32'(busy), 32'h0);
    chk("areset_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("areset_idle_y", 32'(y), 32'h0);
    chk("areset_idle_busy", 32'(busy), 32'h0);
    chk("areset_idle_ready", 32'(in_ready), 32'h1);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      en       = ($urandom_range(0, 24) != 0);
      in_valid = 1'($urandom_range(0, 1));
      sel      = 3'($urandom_range(0, 7));
      mode     = 2'($urandom_range(0, 3));
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
